// File: rtl/issue_sched_pkg.sv
// Shared types and defaults for the issue scheduler.
// Optional statistics counters are enabled with ISSUE_SCHED_STATS_EN.
package issue_sched_pkg;

    localparam int unsigned DEF_RS_IDX_WIDTH = 2;
    localparam int unsigned DEF_FU_LATENCY   = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK,
        BUSY
    } sched_state_t;

    // busy_cnt only needs to hold FU_LATENCY-1; keep at least one bit.
    function automatic int unsigned busy_cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, searching circularly.
module rr_arbiter #(
    parameter int unsigned NUM_RS       = 4,
    parameter int unsigned RS_IDX_WIDTH = 2
) (
    input  logic [NUM_RS-1:0]       req,
    input  logic [RS_IDX_WIDTH-1:0] ptr,
    output logic                    valid,
    output logic [RS_IDX_WIDTH-1:0] idx
);

    logic [RS_IDX_WIDTH-1:0] cand;

    // NUM_RS is a power of two, so the index add wraps on its own.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            cand = ptr + RS_IDX_WIDTH'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Round-robin issue scheduler sharing one FU among NUM_RS issue queues.
// Define ISSUE_SCHED_STATS_EN to build the issued/nack statistics counters and ports.
module issue_scheduler
    import issue_sched_pkg::*;
#(
    parameter int unsigned NUM_RS       = 4,
    parameter int unsigned RS_IDX_WIDTH = DEF_RS_IDX_WIDTH,
    parameter int unsigned FU_LATENCY   = DEF_FU_LATENCY
`ifdef ISSUE_SCHED_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH    = 16
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_RS-1:0]       rs_req,
    input  logic [NUM_RS-1:0]       rs_issue_ready,
    output logic [NUM_RS-1:0]       rs_issue,
    output logic                    fu_start,
    output logic [RS_IDX_WIDTH-1:0] fu_src_sel,
    output logic                    sched_busy
`ifdef ISSUE_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]    issued_cnt,
    output logic [CNT_WIDTH-1:0]    nack_cnt
`endif
);

    localparam int unsigned BusyW = busy_cnt_width(FU_LATENCY);

    sched_state_t            state_q;
    logic [RS_IDX_WIDTH-1:0] rr_ptr_q;
    logic [RS_IDX_WIDTH-1:0] grant_q;
    logic [BusyW-1:0]        busy_cnt_q;
    logic                    arb_valid;
    logic [RS_IDX_WIDTH-1:0] arb_idx;
    logic                    ack_hit;

    rr_arbiter #(
        .NUM_RS       (NUM_RS),
        .RS_IDX_WIDTH (RS_IDX_WIDTH)
    ) u_arb (
        .req   (rs_req),
        .ptr   (rr_ptr_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign ack_hit = rs_issue_ready[grant_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            busy_cnt_q <= '0;
            fu_start   <= 1'b0;
            fu_src_sel <= '0;
        end else begin
            fu_start <= 1'b0;
            if (flush) begin
                state_q    <= IDLE;
                busy_cnt_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arb_valid) begin
                            grant_q <= arb_idx;
                            state_q <= ISSUE;
                        end
                    end
                    ISSUE: state_q <= ACK;
                    ACK: begin
                        rr_ptr_q <= grant_q + 1'b1;
                        if (ack_hit) begin
                            fu_start   <= 1'b1;
                            fu_src_sel <= grant_q;
                            busy_cnt_q <= BusyW'(FU_LATENCY - 1);
                            state_q    <= (FU_LATENCY > 1) ? BUSY : IDLE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    BUSY: begin
                        // Leave on the cycle the count reaches zero, giving FU_LATENCY-1 BUSY cycles.
                        if (busy_cnt_q <= BusyW'(1)) begin
                            busy_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            busy_cnt_q <= busy_cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rs_issue = '0;
        if (state_q == ISSUE) begin
            rs_issue[grant_q] = 1'b1;
        end
    end

    assign sched_busy = (state_q != IDLE);

`ifdef ISSUE_SCHED_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= '0;
            nack_cnt   <= '0;
        end else if (!flush && state_q == ACK) begin
            if (ack_hit) begin
                if (issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
            end else begin
                if (nack_cnt != '1) nack_cnt <= nack_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler; dut uses FU_LATENCY=3, dut1 uses FU_LATENCY=1.
module tb_issue_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] rs_req = '0;
    logic [3:0] rs_issue_ready = '0;

    logic [3:0] rs_issue, rs_issue1;
    logic       fu_start, fu_start1;
    logic [1:0] fu_src_sel, fu_src_sel1;
    logic       sched_busy, sched_busy1;
`ifdef ISSUE_SCHED_STATS_EN
    logic [15:0] issued_cnt, nack_cnt, issued_cnt1, nack_cnt1;
`endif

    int errors = 0;
    int checks = 0;
    int sb[$];

    issue_scheduler #(.FU_LATENCY(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .rs_req         (rs_req),
        .rs_issue_ready (rs_issue_ready),
        .rs_issue       (rs_issue),
        .fu_start       (fu_start),
        .fu_src_sel     (fu_src_sel),
        .sched_busy     (sched_busy)
`ifdef ISSUE_SCHED_STATS_EN
        ,
        .issued_cnt     (issued_cnt),
        .nack_cnt       (nack_cnt)
`endif
    );

    issue_scheduler #(.FU_LATENCY(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .rs_req         (rs_req),
        .rs_issue_ready (rs_issue_ready),
        .rs_issue       (rs_issue1),
        .fu_start       (fu_start1),
        .fu_src_sel     (fu_src_sel1),
        .sched_busy     (sched_busy1)
`ifdef ISSUE_SCHED_STATS_EN
        ,
        .issued_cnt     (issued_cnt1),
        .nack_cnt       (nack_cnt1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched_busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(sched_busy), 32'd0);
    endtask

    // One isolated transaction: req/ack presented in IDLE cycle t, outputs checked at t+1..t+3.
    task automatic do_op(input logic [3:0] req, input logic [3:0] ack, input int g,
                         input bit acc, input string tag);
        wait_idle();
        rs_req = req;
        rs_issue_ready = ack;
        if (acc) sb.push_back(g);
        tick();
        check({tag, "_issue"}, 32'(rs_issue), 32'(1 << g));
        check({tag, "_busy"}, 32'(sched_busy), 32'd1);
        rs_req = '0;
        tick();
        check({tag, "_issue_off"}, 32'(rs_issue), 32'd0);
        tick();
        check({tag, "_fu_start"}, 32'(fu_start), 32'(acc));
        if (fu_start === 1'b1) begin
            if (sb.size() > 0) check({tag, "_src_sel"}, 32'(fu_src_sel), 32'(sb.pop_front()));
            else check({tag, "_unexpected_start"}, 32'(fu_start), 32'd0);
        end else if (acc && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        rs_issue_ready = '0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_issue", 32'(rs_issue), 32'd0);
        check("rst_fu_start", 32'(fu_start), 32'd0);
        check("rst_src_sel", 32'(fu_src_sel), 32'd0);
        check("rst_busy", 32'(sched_busy), 32'd0);
        check("rst_busy1", 32'(sched_busy1), 32'd0);
        #2 reset = 1'b1;

        // Single requester 2, then rr_ptr must sit at 3
        do_op(4'b0100, 4'b0100, 2, 1'b1, "t2");
        do_op(4'b1111, 4'b1111, 3, 1'b1, "t2_ptr");

        // Nack on queue 0 (ack on a non-granted bit is ignored), then queue 1 is next
        do_op(4'b0011, 4'b0010, 0, 1'b0, "t4_nack");
`ifdef ISSUE_SCHED_STATS_EN
        check("t4_nack_cnt", 32'(nack_cnt), 32'd1);
        check("t4_issued_cnt", 32'(issued_cnt), 32'd2);
`endif
        do_op(4'b0011, 4'b0010, 1, 1'b1, "t4_next");

        // FU_LATENCY=3 with request held: next issue five cycles after the previous one
        wait_idle();
        rs_req = 4'b0001;
        rs_issue_ready = 4'b0001;
        tick();
        check("t5_issue0", 32'(rs_issue), 32'd1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("t5_gap", 32'(rs_issue), 32'd0);
            if (c == 3) begin
                check("t5_fu_start", 32'(fu_start), 32'd1);
                check("t5_src_sel", 32'(fu_src_sel), 32'd0);
            end
            if (c == 4) begin
                check("t5_busy", 32'(sched_busy), 32'd1);
                check("t5_start_off", 32'(fu_start), 32'd0);
            end
            if (c == 5) check("t5_idle", 32'(sched_busy), 32'd0);
        end
        tick();
        check("t5_issue1", 32'(rs_issue), 32'd1);
        rs_req = '0;
        wait_idle();
        rs_issue_ready = '0;
`ifdef ISSUE_SCHED_STATS_EN
        check("t5_issued_cnt", 32'(issued_cnt), 32'd5);
`endif

        // Flush in ACK with ack asserted
        rs_req = 4'b0010;
        rs_issue_ready = 4'b0010;
        tick();
        check("t6_issue", 32'(rs_issue), 32'b0010);
        rs_req = '0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_no_start", 32'(fu_start), 32'd0);
        check("t6_idle", 32'(sched_busy), 32'd0);
`ifdef ISSUE_SCHED_STATS_EN
        check("t6_issued_cnt", 32'(issued_cnt), 32'd5);
        check("t6_nack_cnt", 32'(nack_cnt), 32'd1);
`endif
        do_op(4'b1111, 4'b1111, 1, 1'b1, "t6_ptr");

        // Async reset while dut is in BUSY
        wait_idle();
        rs_req = 4'b1000;
        rs_issue_ready = 4'b1000;
        tick();
        rs_req = '0;
        tick();
        tick();
        check("t1_fu_start", 32'(fu_start), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t1_issue", 32'(rs_issue), 32'd0);
        check("t1_fu_start_clr", 32'(fu_start), 32'd0);
        check("t1_busy", 32'(sched_busy), 32'd0);
`ifdef ISSUE_SCHED_STATS_EN
        check("t1_issued_cnt", 32'(issued_cnt), 32'd0);
`endif
        #2 reset = 1'b1;
        sb.delete();

        // All queues requesting, always ack: FU_LATENCY=1 grants 0,1,2,3,0 every 3 cycles
        rs_req = 4'b1111;
        rs_issue_ready = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) check("t1_first_grant", 32'(rs_issue), 32'd1);
            if (c % 3 == 1) begin
                check("t3_issue", 32'(rs_issue1), 32'(1 << (((c - 1) / 3) % 4)));
                sb.push_back(((c - 1) / 3) % 4);
            end else begin
                check("t3_issue_off", 32'(rs_issue1), 32'd0);
            end
            check("t3_fu_start", 32'(fu_start1), 32'(c % 3 == 0));
            if (fu_start1 === 1'b1 && sb.size() > 0)
                check("t3_src_sel", 32'(fu_src_sel1), 32'(sb.pop_front()));
        end
        rs_req = '0;
        rs_issue_ready = '0;
        wait_idle();
        check("final_busy1", 32'(sched_busy1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
